ayatsuki_mem_arbiter: RTL

//  Shares one single-port, synchronous-read word RAM between the core's fetch port and its load/store port.

---
 rtl/ayatsuki_mem_arbiter_pkg.sv | 15 +
 rtl/ayatsuki_mem_arbiter.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/ayatsuki_mem_arbiter_pkg.sv
// Shared types and constants for the ayatsuki fetch/data memory arbiter.
package ayatsuki_mem_arbiter_pkg;

  typedef enum logic [0:0] {
    ARB_FETCH   = 1'b0,
    ARB_REFETCH = 1'b1
  } arb_state_e;

  typedef logic [31:0] inst_bus_t;
  typedef logic [31:0] data_bus_t;

  localparam inst_bus_t INST_NOP  = 32'h0000_0013;
  localparam data_bus_t DATA_ZERO = 32'h0000_0000;

endpackage

// File: rtl/ayatsuki_mem_arbiter.sv
// Arbitrates one single-port sync-read RAM between instruction fetch and the
// load/store port; a data access steals the port and stalls the core 2 cycles.
module ayatsuki_mem_arbiter
  import ayatsuki_mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned RAM_AW = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] inst_addr_i,
  output logic [31:0]       inst_o,
  input  logic              mem_enable_i,
  input  logic              mem_r_enable_i,
  input  logic              mem_w_enable_i,
  input  logic [ADDR_W-1:0] mem_r_addr_i,
  input  logic [ADDR_W-1:0] mem_w_addr_i,
  input  logic [31:0]       mem_w_data_i,
  output logic [31:0]       mem_data_o,
  output logic              stall_o,
  output logic              ram_en_o,
  output logic              ram_we_o,
  output logic [RAM_AW-1:0] ram_addr_o,
  output logic [31:0]       ram_wdata_o,
  input  logic [31:0]       ram_rdata_i
);

  arb_state_e state_q, state_d;
  logic       fetch_q, fetch_d;
  logic       served_q, served_d;
  logic       rd_pend_q, rd_pend_d;
  inst_bus_t  inst_hold_q, inst_hold_d;
  data_bus_t  data_q, data_d;

  logic              dreq_s;
  logic              wr_s;
  logic              grant_s;
  logic [ADDR_W-1:0] daddr_s;
  logic              d_in_range_s;
  logic              f_in_range_s;
  inst_bus_t         inst_s;
  logic              unused_s;

  // Write wins when both strobes are up, so the write address selects.
  assign wr_s         = mem_w_enable_i;
  assign dreq_s       = mem_enable_i & (mem_r_enable_i | mem_w_enable_i);
  assign daddr_s      = wr_s ? mem_w_addr_i : mem_r_addr_i;
  assign d_in_range_s = (daddr_s[ADDR_W-1:RAM_AW+2] == '0);
  assign f_in_range_s = (inst_addr_i[ADDR_W-1:RAM_AW+2] == '0);
  assign grant_s      = (state_q == ARB_FETCH) & dreq_s & ~served_q;
  assign inst_s       = fetch_q ? ram_rdata_i : inst_hold_q;
  assign unused_s     = ^{daddr_s[1:0], inst_addr_i[1:0]};

  // State and flag registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ARB_FETCH;
      fetch_q     <= 1'b0;
      served_q    <= 1'b0;
      rd_pend_q   <= 1'b0;
      inst_hold_q <= INST_NOP;
      data_q      <= DATA_ZERO;
    end else begin
      state_q     <= state_d;
      fetch_q     <= fetch_d;
      served_q    <= served_d;
      rd_pend_q   <= rd_pend_d;
      inst_hold_q <= inst_hold_d;
      data_q      <= data_d;
    end
  end

  // Next-state logic; an out-of-range fetch parks a NOP in the hold register.
  always_comb begin
    state_d     = state_q;
    fetch_d     = fetch_q;
    served_d    = served_q;
    rd_pend_d   = rd_pend_q;
    data_d      = data_q;
    inst_hold_d = inst_s;
    case (state_q)
      ARB_FETCH: begin
        if (grant_s) begin
          state_d   = ARB_REFETCH;
          fetch_d   = 1'b0;
          served_d  = 1'b0;
          rd_pend_d = ~wr_s & d_in_range_s;
        end else begin
          fetch_d   = f_in_range_s;
          served_d  = 1'b0;
          rd_pend_d = 1'b0;
          if (!f_in_range_s) begin
            inst_hold_d = INST_NOP;
          end else begin
            inst_hold_d = inst_s;
          end
        end
      end
      ARB_REFETCH: begin
        state_d   = ARB_FETCH;
        fetch_d   = f_in_range_s;
        served_d  = 1'b1;
        rd_pend_d = 1'b0;
        data_d    = rd_pend_q ? ram_rdata_i : DATA_ZERO;
        if (!f_in_range_s) begin
          inst_hold_d = INST_NOP;
        end else begin
          inst_hold_d = inst_s;
        end
      end
      default: begin
        state_d   = ARB_FETCH;
        fetch_d   = 1'b0;
        served_d  = 1'b0;
        rd_pend_d = 1'b0;
      end
    endcase
  end

  // Port steering and core-facing outputs; everything is quiet while in reset.
  always_comb begin
    inst_o      = inst_s;
    stall_o     = 1'b0;
    ram_en_o    = 1'b0;
    ram_we_o    = 1'b0;
    ram_addr_o  = inst_addr_i[RAM_AW+1:2];
    ram_wdata_o = mem_w_data_i;
    mem_data_o  = DATA_ZERO;
    if (!rst_n) begin
      inst_o = INST_NOP;
    end else begin
      case (state_q)
        ARB_FETCH: begin
          if (grant_s) begin
            stall_o    = 1'b1;
            ram_en_o   = d_in_range_s;
            ram_we_o   = wr_s & d_in_range_s;
            ram_addr_o = daddr_s[RAM_AW+1:2];
          end else begin
            ram_en_o   = f_in_range_s;
            mem_data_o = served_q ? data_q : DATA_ZERO;
          end
        end
        ARB_REFETCH: begin
          stall_o  = 1'b1;
          ram_en_o = f_in_range_s;
        end
        default: begin
          stall_o = 1'b0;
        end
      endcase
    end
  end

endmodule
